// File: rtl/cdc_handshake_tx_pkg.sv
// -----------------------------------------------------------------------------
// cdc_handshake_tx_pkg
// Shared definitions for the 4-phase req/ack clock-domain-crossing handshake.
// The tx (source) and rx (destination) ends both import this package.
//   cdc_hs_tx_state_e    : source-side FSM states
//   CDC_SYNC_STAGES_MIN/ : legal depth range of the synchronizer chains
//   CDC_SYNC_STAGES_MAX
//   sync_stages_legal()  : range check used when sizing a synchronizer
// -----------------------------------------------------------------------------
package cdc_handshake_tx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    ACK_LO = 2'd2
  } cdc_hs_tx_state_e;

  localparam int unsigned CDC_SYNC_STAGES_MIN = 32'd2;
  localparam int unsigned CDC_SYNC_STAGES_MAX = 32'd4;

  function automatic logic sync_stages_legal(input int unsigned stages);
    return (stages >= CDC_SYNC_STAGES_MIN) && (stages <= CDC_SYNC_STAGES_MAX);
  endfunction

endpackage

// File: rtl/sync_chain_srst.sv
// -----------------------------------------------------------------------------
// sync_chain_srst
// Single-bit multi-flop synchronizer with a synchronous, active-high reset
// that clears every stage to 0.
//   clk_i : destination (sampling) clock
//   rst_i : synchronous active-high reset
//   d_i   : asynchronous input bit
//   q_o   : d_i after STAGES flops
// A depth outside the shared legal range is pulled to the nearest legal
// value so the chain never degenerates into a single flop.
// -----------------------------------------------------------------------------
module sync_chain_srst
  import cdc_handshake_tx_pkg::*;
#(
  parameter int unsigned STAGES = 32'd2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  localparam int unsigned DEPTH =
    sync_stages_legal(STAGES) ? STAGES :
    ((STAGES < CDC_SYNC_STAGES_MIN) ? CDC_SYNC_STAGES_MIN : CDC_SYNC_STAGES_MAX);

  logic [DEPTH-1:0] sync_q;

  // Shift the asynchronous bit through the flop chain; bit 0 is the first
  // (metastability-exposed) stage.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[DEPTH-2:0], d_i};
    end
  end

  assign q_o = sync_q[DEPTH-1];

endmodule

// File: rtl/cdc_handshake_tx.sv
// -----------------------------------------------------------------------------
// cdc_handshake_tx
// Source-domain end of a 4-phase (return-to-zero) req/ack CDC handshake.
// A word accepted with valid/ready is held on xfer_data_o while a level
// request is raised; the destination's acknowledge is synchronized locally,
// the request is dropped, and once the acknowledge has returned low the
// transfer is complete and the next word may be accepted.
//   clk_i       : source-domain clock
//   rst_i       : synchronous active-high reset
//   data_i      : word to send
//   valid_i     : data_i valid
//   ready_o     : a word can be accepted this cycle
//   xfer_data_o : registered crossing data, stable while a transfer is open
//   xfer_req_o  : registered request level to the destination domain
//   xfer_ack_i  : acknowledge from the destination (asynchronous)
//   done_o      : one-cycle pulse when a transfer completes (ack back low)
// -----------------------------------------------------------------------------
module cdc_handshake_tx
  import cdc_handshake_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32'd8,
  parameter int unsigned SYNC_STAGES = 32'd2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic [DATA_WIDTH-1:0] xfer_data_o,
  output logic                  xfer_req_o,
  input  logic                  xfer_ack_i,
  output logic                  done_o
);

  cdc_hs_tx_state_e      state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  req_q, req_d;
  logic                  done_q, done_d;
  logic                  ack_s;
  logic                  accept_s;

  // The acknowledge only ever reaches the FSM through the synchronizer, so
  // no output has a combinational path from xfer_ack_i.
  sync_chain_srst #(
    .STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (xfer_ack_i),
    .q_o   (ack_s)
  );

  // A still-high acknowledge (stale after a reset, or spurious) blocks new
  // words so a fresh request can never overlap an old acknowledge.
  assign ready_o  = (state_q == IDLE) && !ack_s;
  assign accept_s = valid_i && ready_o;

  // Next-state, request level, crossing data and completion pulse.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    req_d   = req_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          data_d  = data_i;
          req_d   = 1'b1;
          state_d = REQ;
        end else begin
          req_d   = 1'b0;
        end
      end
      REQ: begin
        // Pure level wait: a low ack here changes nothing.
        if (ack_s) begin
          req_d   = 1'b0;
          state_d = ACK_LO;
        end else begin
          req_d   = 1'b1;
        end
      end
      ACK_LO: begin
        if (!ack_s) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          req_d   = 1'b0;
        end
      end
      default: begin
        // Unused encoding: fall back to a safe idle with the request low.
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State, crossing data, request and completion registers; a reset mid
  // transfer drops the request at once and suppresses the done pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      data_q  <= '0;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      req_q   <= req_d;
      done_q  <= done_d;
    end
  end

  assign xfer_data_o = data_q;
  assign xfer_req_o  = req_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// -----------------------------------------------------------------------------
// tb_cdc_handshake_tx
// Self-checking bench for cdc_handshake_tx (DATA_WIDTH=32, SYNC_STAGES=3).
// A destination responder echoes req to ack with a configurable delay and
// records the word present at each ack rise; a monitor tracks accepted words
// and the rules that hold every cycle.
// -----------------------------------------------------------------------------
module tb_cdc_handshake_tx;

  localparam int DW = 32;
  localparam int SS = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] data;
  logic          valid;
  logic          ready;
  logic [DW-1:0] xdata;
  logic          xreq;
  logic          xack;
  logic          done;

  always #5 clk = ~clk;

  cdc_handshake_tx #(
    .DATA_WIDTH  (DW),
    .SYNC_STAGES (SS)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .data_i      (data),
    .valid_i     (valid),
    .ready_o     (ready),
    .xfer_data_o (xdata),
    .xfer_req_o  (xreq),
    .xfer_ack_i  (xack),
    .done_o      (done)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- destination responder ----------------
  logic resp_en   = 1'b0;
  logic resp_rand = 1'b0;
  logic resp_ack  = 1'b0;
  logic man_ack   = 1'b0;
  int   resp_cnt  = 0;
  int   resp_dly  = 3;
  logic [DW-1:0] rx_q[$];

  assign xack = resp_en ? resp_ack : man_ack;

  initial begin
    forever begin
      @(posedge clk); #1;
      if (!resp_en) begin
        resp_ack = 1'b0;
        resp_cnt = 0;
      end else if (xreq !== resp_ack) begin
        resp_cnt++;
        if (resp_cnt >= resp_dly) begin
          resp_ack = xreq;
          if (xreq) rx_q.push_back(xdata);
          resp_cnt = 0;
          resp_dly = resp_rand ? int'($urandom_range(7, 1)) : 3;
        end
      end else begin
        resp_cnt = 0;
      end
    end
  end

  // ---------------- monitor / reference rules ----------------
  logic          mon_en    = 1'b0;
  logic [SS-1:0] ack_hist  = '0;   // ack as seen SS source edges later
  logic          prev_ack_s = 1'b0;
  logic          prev_req  = 1'b0;
  logic          prev_done = 1'b0;
  logic          prev_acc  = 1'b0;
  logic [DW-1:0] exp_xdata = '0;
  int            done_cnt  = 0;
  logic [DW-1:0] acc_q[$];

  always @(posedge clk) begin
    ack_hist <= rst ? '0 : {ack_hist[SS-2:0], xack};
  end

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      check_eq("xdata_hold", xdata, exp_xdata);
      check_eq("ready_vs_ack_s", ready & ack_hist[SS-1], 1'b0);
      check_eq("ready_vs_req", ready & xreq, 1'b0);
      if (prev_acc) check_eq("req_after_accept", xreq, 1'b1);
      if (xreq && !prev_req) check_eq("req_rise_ack_s", prev_ack_s, 1'b0);
      if (prev_done) check_eq("done_one_cycle", done, 1'b0);
      if (done) done_cnt <= done_cnt + 1;
      if (valid && ready) acc_q.push_back(data);
    end
    exp_xdata  <= rst ? '0 : ((valid && ready) ? data : exp_xdata);
    prev_acc   <= !rst && valid && ready;
    prev_req   <= xreq;
    prev_done  <= done;
    prev_ack_s <= ack_hist[SS-1];
  end

  // ---------------- helpers ----------------
  task automatic send_word(input logic [DW-1:0] w, input string tag);
    logic got;
    got   = 1'b0;
    valid = 1'b1;
    data  = w;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (ready) begin
        got = 1'b1;
        break;
      end
    end
    check_eq(tag, got, 1'b1);
    @(posedge clk); #1;
    valid = 1'b0;
    data  = $urandom;
  endtask

  task automatic wait_idle(input string tag);
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (ready && !xreq && !xack) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq(tag, ok, 1'b1);
    @(posedge clk); #1;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int hi, lo, seen, extra, cnt, d0;
    logic rdy_at_done;
    logic [DW-1:0] sent[16];

    rst = 1'b1; valid = 1'b0; data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    mon_en = 1'b1;

    // 1: reset state with ack low
    @(negedge clk);
    check_eq("rst_ready", ready, 1'b1);
    check_eq("rst_req", xreq, 1'b0);
    check_eq("rst_xdata", xdata, 32'h0);
    check_eq("rst_done", done, 1'b0);
    @(posedge clk); #1;

    // 2: single word, 3-cycle echo each way, exact latencies
    resp_en = 1'b1; resp_rand = 1'b0;
    rx_q.delete();
    send_word(32'h0000_00A5, "t2_accept");
    @(negedge clk);
    check_eq("t2_req_up", xreq, 1'b1);
    check_eq("t2_xdata", xdata, 32'h0000_00A5);
    hi = 1; lo = 0; seen = 0; rdy_at_done = 1'b0;
    for (int k = 0; k < 100 && seen == 0; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        rdy_at_done = ready;
      end else if (xreq) hi++;
      else lo++;
    end
    check_eq("t2_done_seen", seen, 1);
    check_eq("t2_req_high_cycles", hi, SS + 3);
    check_eq("t2_req_low_to_done", lo, SS + 3);
    check_eq("t2_ready_at_done", rdy_at_done, 1'b1);
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) extra++;
    end
    check_eq("t2_single_done", extra, 0);
    check_eq("t2_rx_count", rx_q.size(), 1);
    if (rx_q.size() > 0) check_eq("t2_rx_word", rx_q[0], 32'h0000_00A5);
    @(posedge clk); #1;

    // 3: valid held high, incrementing data
    acc_q.delete(); rx_q.delete(); d0 = done_cnt;
    valid = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      data = k;
      @(posedge clk); #1;
    end
    valid = 1'b0;
    wait_idle("t3_idle");
    check_eq("t3_some_accepted", acc_q.size() >= 3, 1'b1);
    check_eq("t3_rx_count", rx_q.size(), acc_q.size());
    for (int i = 0; i < acc_q.size() && i < rx_q.size(); i++)
      check_eq("t3_rx_word", rx_q[i], acc_q[i]);
    for (int i = 1; i < acc_q.size(); i++)
      check_eq("t3_increasing", acc_q[i] > acc_q[i-1], 1'b1);
    check_eq("t3_done_count", done_cnt - d0, acc_q.size());

    // 4: reset while in REQ with ack already high
    resp_en = 1'b0; man_ack = 1'b0; d0 = done_cnt;
    send_word(32'h0000_0077, "t4_accept");
    man_ack = 1'b1;
    @(negedge clk);
    check_eq("t4_req_up", xreq, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("t4_req_dropped", xreq, 1'b0);
    check_eq("t4_no_done", done, 1'b0);
    cnt = 1; hi = 0;
    for (int k = 0; k < SS + 5; k++) begin
      @(negedge clk);
      if (ready) cnt++;
      if (xreq || done) hi++;
    end
    check_eq("t4_ready_until_chain_fills", cnt, SS);
    check_eq("t4_no_req_no_done", hi, 0);
    check_eq("t4_ready_low_ack_high", ready, 1'b0);
    @(posedge clk); #1;
    man_ack = 1'b0;
    cnt = 0; seen = 0;
    for (int k = 0; k < 20 && seen == 0; k++) begin
      @(negedge clk);
      if (ready) seen = 1;
      else cnt++;
    end
    check_eq("t4_ready_returns", seen, 1);
    check_eq("t4_ready_low_after_ack_drop", cnt, SS);
    @(posedge clk); #1;
    check_eq("t4_no_done_total", done_cnt - d0, 0);

    // 5: spurious ack pulse in IDLE, then a normal transfer
    d0 = done_cnt;
    man_ack = 1'b1;
    cnt = 0; hi = 0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (!ready) cnt++;
      if (xreq || done) hi++;
      @(posedge clk); #1;
      if (k == 4) man_ack = 1'b0;
    end
    check_eq("t5_ready_low_cycles", cnt, 5);
    check_eq("t5_no_req_no_done", hi, 0);
    resp_en = 1'b1; rx_q.delete();
    send_word(32'h0000_003C, "t5_accept");
    wait_idle("t5_idle");
    check_eq("t5_rx_count", rx_q.size(), 1);
    if (rx_q.size() > 0) check_eq("t5_rx_word", rx_q[0], 32'h0000_003C);
    check_eq("t5_done_count", done_cnt - d0, 1);

    // 6: 16 random words, random ack delays 1..7
    resp_rand = 1'b1; rx_q.delete(); d0 = done_cnt;
    for (int i = 0; i < 16; i++) begin
      sent[i] = $urandom;
      repeat ($urandom_range(3, 0)) begin
        @(posedge clk); #1;
      end
      send_word(sent[i], "t6_accept");
    end
    wait_idle("t6_idle");
    check_eq("t6_rx_count", rx_q.size(), 16);
    for (int i = 0; i < 16 && i < rx_q.size(); i++)
      check_eq("t6_rx_word", rx_q[i], sent[i]);
    check_eq("t6_done_count", done_cnt - d0, 16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
